// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: mult/multu/div/divu one bit per cycle, plus mthi/mtlo.
// Define HILO_MULDIV_DIV_EN to build the divider; without it div/divu complete at once with no write.
module hilo_muldiv (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e      state;
   logic [5:0]  cnt;
   logic        neg_q;
   logic        skip;
   logic [31:0] opnd;
   logic [63:0] prod;

   logic        a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic [32:0] sum;
   logic [63:0] prod_fix;

`ifdef HILO_MULDIV_DIV_EN
   logic        is_div, neg_r, skip_dz;
   logic [31:0] rem;
   logic [32:0] shifted;
   logic        q_bit;
   logic [31:0] diff;
   logic [31:0] quo_fix, rem_fix;
`endif

   // opnd holds the multiplicand (mult) or divisor (div); prod[31:0] holds multiplier or dividend
   always_comb begin
      a_neg    = ~op[0] & A[31];
      b_neg    = ~op[0] & B[31];
      a_abs    = a_neg ? 32'd0 - A : A;
      b_abs    = b_neg ? 32'd0 - B : B;
      sum      = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
      prod_fix = neg_q ? 64'd0 - prod : prod;
`ifdef HILO_MULDIV_DIV_EN
      shifted  = {rem, prod[31]};
      q_bit    = shifted >= {1'b0, opnd};
      // partial remainder stays below the divisor, so the low 32 bits carry the difference
      diff     = shifted[31:0] - opnd;
      quo_fix  = neg_q ? 32'd0 - prod[31:0] : prod[31:0];
      rem_fix  = neg_r ? 32'd0 - rem : rem;
`endif
   end

   assign busy = (state != StIdle);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= StIdle;
         cnt      <= 6'd0;
         neg_q    <= 1'b0;
         skip     <= 1'b0;
         opnd     <= 32'd0;
         prod     <= 64'd0;
         HI       <= 32'd0;
         LO       <= 32'd0;
         done     <= 1'b0;
         div_zero <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
         is_div   <= 1'b0;
         neg_r    <= 1'b0;
         skip_dz  <= 1'b0;
         rem      <= 32'd0;
`endif
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start && !op[2]) begin
                  cnt   <= 6'd0;
                  neg_q <= a_neg ^ b_neg;
                  skip  <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
                  is_div  <= op[1];
                  neg_r   <= a_neg;
                  skip_dz <= 1'b0;
                  rem     <= 32'd0;
                  if (op[1]) begin
                     opnd <= b_abs;
                     prod <= {32'd0, a_abs};
                     if (B == 32'd0) begin
                        skip    <= 1'b1;
                        skip_dz <= 1'b1;
                        state   <= StFix;
                     end else begin
                        state <= StCalc;
                     end
                  end else begin
                     opnd  <= a_abs;
                     prod  <= {32'd0, b_abs};
                     state <= StCalc;
                  end
`else
                  opnd <= a_abs;
                  prod <= {32'd0, b_abs};
                  if (op[1]) begin
                     skip  <= 1'b1;
                     state <= StFix;
                  end else begin
                     state <= StCalc;
                  end
`endif
               end else if (start && !op[1]) begin
                  if (op[0]) LO <= A;
                  else       HI <= A;
               end
            end
            StCalc: begin
`ifdef HILO_MULDIV_DIV_EN
               if (is_div) begin
                  rem  <= q_bit ? diff : shifted[31:0];
                  prod <= {prod[63:32], prod[30:0], q_bit};
               end else begin
                  prod <= {sum, prod[31:1]};
               end
`else
               prod <= {sum, prod[31:1]};
`endif
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= StFix;
            end
            StFix: begin
               done  <= 1'b1;
               state <= StIdle;
`ifdef HILO_MULDIV_DIV_EN
               div_zero <= skip_dz;
               if (!skip && is_div) begin
                  LO <= quo_fix;
                  HI <= rem_fix;
               end else if (!skip) begin
                  {HI, LO} <= prod_fix;
               end
`else
               if (!skip) {HI, LO} <= prod_fix;
`endif
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random ops against an arithmetic model.
// Expectations for div/divu follow HILO_MULDIV_DIV_EN the same way the design does.
module tb_hilo_muldiv;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy, done, div_zero;
   logic [31:0] HI, LO;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   hilo_muldiv dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero as MIPS does
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int elat, output logic edz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa   = $signed(a);
      sb   = $signed(b);
      elat = 33;
      edz  = 1'b0;
      case (o)
         3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         default: begin
`ifdef HILO_MULDIV_DIV_EN
            if (b == 32'd0) begin
               elat = 1;
               edz  = 1'b1;
            end else if (o == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               p = q; m_lo = p[31:0];
               p = r; m_hi = p[31:0];
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
`else
            elat = 1;
`endif
         end
      endcase
   endtask

   task automatic wait_done(inout int lat);
      while (done !== 1'b1 && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      int   elat, lat;
      logic edz;
      model(o, a, b, elat, edz);
      @(negedge CLK);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge CLK); #1;
      start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      lat = 0;
      wait_done(lat);
      chk({tag, " latency"}, lat, elat);
      chk({tag, " busy@done"}, 32'(busy), 32'd0);
      chk({tag, " div_zero"}, 32'(div_zero), 32'(edz));
      chk({tag, " HI"}, HI, m_hi);
      chk({tag, " LO"}, LO, m_lo);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      if (o == 3'd4) m_hi = a;
      else           m_lo = a;
      @(negedge CLK);
      start = 1'b1; op = o; A = a;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("mt busy", 32'(busy), 32'd0);
      chk("mt done", 32'(done), 32'd0);
      chk("mt HI", HI, m_hi);
      chk("mt LO", LO, m_lo);
   endtask

   initial begin
      int          lat;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      RST_N = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
      #12;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst div_zero", 32'(div_zero), 32'd0);
      chk("rst HI", HI, 32'd0);
      chk("rst LO", LO, 32'd0);
      @(negedge CLK); RST_N = 1'b1;

      do_op(3'd0, 32'hFFFF_FFFF, 32'd2, "mult -1x2");
      do_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu ffffffffx2");
      do_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult minxmin");
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
      do_op(3'd3, 32'd100, 32'd7, "divu 100/7");
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
      do_op(3'd2, 32'd7, 32'hFFFF_FFFE, "div 7/-2");

      mt(3'd4, 32'h1234);
      mt(3'd5, 32'h5678);
      do_op(3'd2, 32'd5, 32'd0, "div 5/0");
      do_op(3'd3, 32'd5, 32'd0, "divu 5/0");

      // Reserved op must leave everything untouched
      @(negedge CLK);
      start = 1'b1; op = 3'b110; A = 32'hDEAD_BEEF;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("rsvd busy", 32'(busy), 32'd0);
      @(posedge CLK); #1;
      chk("rsvd done", 32'(done), 32'd0);
      chk("rsvd HI", HI, m_hi);
      chk("rsvd LO", LO, m_lo);

      // A start arriving mid-iteration is dropped
      model(3'd0, 32'd3, 32'd4, lat, ro[0]);
      @(negedge CLK);
      start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
      @(posedge CLK); #1;
      start = 1'b0;
      lat = 0;
      repeat (10) begin @(posedge CLK); #1; lat++; end
      @(negedge CLK);
      start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      start = 1'b0;
      lat++;
      wait_done(lat);
      chk("ignore latency", lat, 33);
      chk("ignore HI", HI, m_hi);
      chk("ignore LO", LO, m_lo);
      chk("b2b done", 32'(done), 32'd1);
      do_op(3'd0, 32'd7, 32'd6, "b2b mult");

      // Asynchronous reset mid-CALC
      @(negedge CLK);
      start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (20) @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst done", 32'(done), 32'd0);
      chk("arst HI", HI, 32'd0);
      chk("arst LO", LO, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge CLK); RST_N = 1'b1;
      do_op(3'd0, 32'd7, 32'd6, "post-rst mult");

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (ro[2]) mt(ro, ra);
         else       do_op(ro, ra, rb, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
